// File: rtl/pipe_ctl_pkg.sv
// rtl/pipe_ctl_pkg.sv - shared helpers for the stall-able pipeline register chain
package pipe_ctl_pkg;

  // Adds inc to count and clamps at 2^cnt_w-1 so multi-entry adds never wrap.
  function automatic logic [31:0] sat_add(input logic [31:0] count, input logic [31:0] inc,
                                          input int cnt_w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, count} + {1'b0, inc};
    lim = (33'd1 << cnt_w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

  function automatic logic [31:0] popcount(input logic [63:0] v, input int depth);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < depth && v[i]) n = n + 32'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// rtl/pipe_stage_cell.sv - one valid+data pipeline register with flush/hold/bubble priority
module pipe_stage_cell
  import pipe_ctl_pkg::*;
#(
  parameter int              WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic             bubble_in,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Flush outranks hold so a stalled stage can still be squashed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= BUBBLE;
    end else if (flush) begin
      valid <= 1'b0;
      data  <= BUBBLE;
    end else if (hold) begin
      valid <= valid;
      data  <= data;
    end else if (bubble_in) begin
      valid <= 1'b0;
      data  <= BUBBLE;
    end else begin
      valid <= prev_valid;
      data  <= prev_data;
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - DEPTH-stage pipeline chain with per-stage stall/flush and perf counters
module pipe_stage_chain
  import pipe_ctl_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               DEPTH  = 4,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DEPTH-1:0]       stall,
  input  logic [DEPTH-1:0]       flush,
  input  logic                   count_clr,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  output logic [CNT_W-1:0]       stall_count,
  output logic [CNT_W-1:0]       squash_count
);

  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [31:0]      stall_next;
  logic [31:0]      squash_next;

  // A stall anywhere downstream freezes every stage upstream of it.
  always_comb begin
    hold = '0;
    hold[DEPTH-1] = stall[DEPTH-1];
    for (int k = DEPTH - 2; k >= 0; k--) begin
      hold[k] = stall[k] | hold[k+1];
    end
  end

  assign in_ready = ~hold[0];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             pv;
    logic [WIDTH-1:0] pd;
    logic             bub;
    if (k == 0) begin : g_head
      assign pv  = in_valid;
      assign pd  = in_valid ? in_data : BUBBLE;
      assign bub = 1'b0;
    end else begin : g_body
      assign pv  = valid_q[k-1];
      assign pd  = data_q[k-1];
      assign bub = stall[k-1];
    end
    pipe_stage_cell #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_cell (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush[k]),
      .hold      (hold[k]),
      .bubble_in (bub),
      .prev_valid(pv),
      .prev_data (pd),
      .valid     (valid_q[k]),
      .data      (data_q[k])
    );
    assign stage_data[k*WIDTH +: WIDTH] = data_q[k];
  end

  assign stage_valid = valid_q;
  assign out_data    = data_q[DEPTH-1];
  assign out_valid   = valid_q[DEPTH-1];

  // Squashes are counted against the valid bits as they stand before the edge.
  always_comb begin
    stall_next  = sat_add(32'(stall_count), {31'd0, |stall}, CNT_W);
    squash_next = sat_add(32'(squash_count), popcount(64'(flush & valid_q), DEPTH), CNT_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count  <= '0;
      squash_count <= '0;
    end else if (count_clr) begin
      stall_count  <= '0;
      squash_count <= '0;
    end else begin
      stall_count  <= stall_next[CNT_W-1:0];
      squash_count <= squash_next[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - scoreboard bench for pipe_stage_chain against a queue-fed reference model
module tb_pipe_stage_chain;

  localparam int          W   = 32;
  localparam int          D   = 4;
  localparam logic [31:0] BUB = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic [D-1:0]  stall = '0;
  logic [D-1:0]  flush = '0;
  logic          count_clr = 1'b0;

  logic          in_ready, out_valid, in_ready_s, out_valid_s;
  logic [D*W-1:0] stage_data, stage_data_s;
  logic [D-1:0]  stage_valid, stage_valid_s;
  logic [W-1:0]  out_data, out_data_s;
  logic [15:0]   stall_count, squash_count;
  logic [1:0]    stall_count_s, squash_count_s;

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .BUBBLE(BUB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .count_clr(count_clr), .stage_data(stage_data),
    .stage_valid(stage_valid), .out_data(out_data), .out_valid(out_valid),
    .stall_count(stall_count), .squash_count(squash_count)
  );

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .BUBBLE(BUB), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_s),
    .stall(stall), .flush(flush), .count_clr(count_clr), .stage_data(stage_data_s),
    .stage_valid(stage_valid_s), .out_data(out_data_s), .out_valid(out_valid_s),
    .stall_count(stall_count_s), .squash_count(squash_count_s)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [D*W-1:0] sd;
    logic [D-1:0]   sv;
    logic [15:0]    sc;
    logic [15:0]    qc;
    logic [1:0]     sc2;
    logic [1:0]     qc2;
    logic           ir;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference: list of D entries, plus unbounded counts clamped to each counter width.
  logic          mv [D];
  logic [W-1:0]  md [D];
  int            msc, msq, msc2, msq2;

  task automatic model_reset();
    for (int k = 0; k < D; k++) begin
      mv[k] = 1'b0;
      md[k] = BUB;
    end
    msc = 0; msq = 0; msc2 = 0; msq2 = 0;
  endtask

  function automatic int clamp(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_step(input logic [D-1:0] st, input logic [D-1:0] fl, input logic iv,
                            input logic [W-1:0] id, input logic clr);
    logic         nv [D];
    logic [W-1:0] nd [D];
    int           squashed;
    squashed = 0;
    for (int k = 0; k < D; k++) begin
      if (fl[k] && mv[k]) squashed++;
      if (fl[k]) begin
        nv[k] = 1'b0; nd[k] = BUB;
      end else if ((st >> k) != 0) begin
        nv[k] = mv[k]; nd[k] = md[k];
      end else if (k == 0) begin
        nv[k] = iv; nd[k] = iv ? id : BUB;
      end else if (st[k-1]) begin
        nv[k] = 1'b0; nd[k] = BUB;
      end else begin
        nv[k] = mv[k-1]; nd[k] = md[k-1];
      end
    end
    for (int k = 0; k < D; k++) begin
      mv[k] = nv[k];
      md[k] = nd[k];
    end
    if (clr) begin
      msc = 0; msq = 0; msc2 = 0; msq2 = 0;
    end else begin
      msc  = clamp(msc  + ((st != 0) ? 1 : 0), 65535);
      msc2 = clamp(msc2 + ((st != 0) ? 1 : 0), 3);
      msq  = clamp(msq  + squashed, 65535);
      msq2 = clamp(msq2 + squashed, 3);
    end
  endtask

  task automatic push_exp(input logic [D-1:0] st);
    exp_t e;
    for (int k = 0; k < D; k++) begin
      e.sd[k*W +: W] = md[k];
      e.sv[k]        = mv[k];
    end
    e.sc  = 16'(msc);
    e.qc  = 16'(msq);
    e.sc2 = 2'(msc2);
    e.qc2 = 2'(msq2);
    e.ir  = (st == 0);
    q.push_back(e);
  endtask

  task automatic drive(input logic [D-1:0] st, input logic [D-1:0] fl, input logic iv,
                       input logic [W-1:0] id, input logic clr, input logic r);
    @(negedge clk);
    rst = r; stall = st; flush = fl; in_valid = iv; in_data = id; count_clr = clr;
    if (r) model_reset();
    else model_step(st, fl, iv, id, clr);
    push_exp(st);
  endtask

  // Reset asserted between edges; the monitor samples the reset state right away.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    push_exp(stall);
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < D; i++) drive('0, '0, 1'b1, 32'({base[7:4], 4'(i)}), 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [D*W-1:0] act, input logic [D*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stage_data",   stage_data, e.sd);
        chk("stage_valid",  128'(stage_valid), 128'(e.sv));
        chk("out_data",     128'(out_data), 128'(e.sd[(D-1)*W +: W]));
        chk("out_valid",    128'(out_valid), 128'(e.sv[D-1]));
        chk("in_ready",     128'(in_ready), 128'(e.ir));
        chk("stall_count",  128'(stall_count), 128'(e.sc));
        chk("squash_count", 128'(squash_count), 128'(e.qc));
        chk("stall_count_w2",  128'(stall_count_s), 128'(e.sc2));
        chk("squash_count_w2", 128'(squash_count_s), 128'(e.qc2));
      end
    end
  end

  initial begin : stimulus
    int waited;
    model_reset();
    drive('0, '0, 1'b0, '0, 1'b0, 1'b1);
    drive('0, '0, 1'b0, '0, 1'b0, 1'b1);

    // flow, then stall[1] bubble with ignored input
    fill(8'hA0);
    drive(4'b0010, '0, 1'b1, 32'hA4, 1'b0, 1'b0);
    drive(4'b0010, '0, 1'b1, 32'hA4, 1'b0, 1'b0);
    drive('0, '0, 1'b1, 32'hA4, 1'b0, 1'b0);
    drive('0, '0, 1'b1, 32'hA5, 1'b0, 1'b0);
    drive('0, '0, 1'b1, 32'hA6, 1'b0, 1'b0);

    // flush beats stall on the same stage
    drive(4'b0100, 4'b0100, 1'b1, 32'hA7, 1'b0, 1'b0);
    drive('0, '0, 1'b0, '0, 1'b0, 1'b0);

    // multi-squash clamp in the narrow counters, then clear beats a repeated flush
    drive('0, '0, 1'b0, '0, 1'b1, 1'b0);
    fill(8'hB0);
    drive('0, 4'b0011, 1'b1, 32'hB8, 1'b0, 1'b0);
    fill(8'hC0);
    drive('0, 4'b0111, 1'b1, 32'hC8, 1'b0, 1'b0);
    fill(8'hD0);
    drive('0, 4'b0111, 1'b1, 32'hD8, 1'b1, 1'b0);

    // async reset while stalled and full
    fill(8'hE0);
    drive(4'b0001, '0, 1'b1, 32'hE8, 1'b0, 1'b0);
    async_reset();
    drive(4'b0001, '0, 1'b0, '0, 1'b0, 1'b1);
    drive('0, '0, 1'b0, '0, 1'b0, 1'b0);

    // input offered while stall[3] holds the chain is not captured
    fill(8'hF0);
    drive(4'b1000, '0, 1'b1, 32'hBB, 1'b0, 1'b0);
    drive(4'b1000, '0, 1'b1, 32'hBB, 1'b0, 1'b0);
    drive('0, '0, 1'b1, 32'hC0, 1'b0, 1'b0);
    for (int i = 0; i < D; i++) drive('0, '0, 1'b0, '0, 1'b0, 1'b0);

    for (int n = 0; n < 600; n++) begin
      logic [D-1:0] st, fl;
      for (int k = 0; k < D; k++) begin
        st[k] = ($urandom_range(0, 7) == 0);
        fl[k] = ($urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 149) == 0) begin
        async_reset();
        drive(st, fl, 1'b1, $urandom, 1'b0, 1'b1);
      end else begin
        drive(st, fl, ($urandom_range(0, 3) != 0), $urandom,
              ($urandom_range(0, 49) == 0), ($urandom_range(0, 199) == 0));
      end
    end

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised successor to the single stall-able pipeline flop.
- Chain of DEPTH pipeline registers, each WIDTH bits, each with a valid bit.
- Per-stage stall, per-stage flush, automatic bubble insertion behind a stall, and saturating stall/squash counters.
- Sits between core pipeline stages (IF/ID..MEM/WB) and is driven by the hazard unit.

Parameters:
- WIDTH, 32, data bits per stage.
- DEPTH, 4, number of stages (>=1).
- BUBBLE, 0 (WIDTH bits), data value written on reset, flush or bubble. Core instances use 32'h00000013 (NOP).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_data  in  WIDTH  data entering stage 0.
- in_valid  in  1  in_data is a real instruction.
- in_ready  out  1  stage 0 accepts this cycle; equals ~hold[0].
- stall  in  DEPTH  stall[k] freezes stage k and every stage upstream of it.
- flush  in  DEPTH  flush[k] squashes stage k.
- count_clr  in  1  synchronous clear of both counters.
- stage_data  out  DEPTH*WIDTH  stage k occupies bits [k*WIDTH +: WIDTH].
- stage_valid  out  DEPTH  valid bit of each stage.
- out_data  out  WIDTH  last stage data.
- out_valid  out  1  last stage valid.
- stall_count  out  CNT_W  cycles with any stall bit set.
- squash_count  out  CNT_W  valid entries squashed by flush.

Behaviour:
- Reset (async, immediate, any time including mid-stall):
  - all stage_valid=0, all stage data=BUBBLE, both counters=0.
  - in_ready=1 once stall is low.
- Combinational hold vector: hold[k] = OR of stall[j] for j>=k, i.e. a downstream stall propagates upstream.
- Per stage k, per rising clk edge, in priority order:
  1. flush[k]=1: valid<=0, data<=BUBBLE. Flush beats stall, so a stalled stage can still be squashed.
  2. hold[k]=1: keep valid and data.
  3. k=0: valid<=in_valid; data<=in_data if in_valid, else BUBBLE.
  4. k>0 and stall[k-1]=1: bubble; valid<=0, data<=BUBBLE. The upstream stage is frozen while this stage advances.
  5. Otherwise: valid<=valid[k-1], data<=data[k-1].
- A flush on stage k does not affect upstream stages. An upstream entry may advance into k on the next cycle.
- Latency: with no stall or flush, an entry appears at out_* exactly DEPTH cycles after it is presented at in_*. Throughput is 1 per cycle.
- stall_count:
  - +1 per cycle when |stall=1.
  - Saturates at 2^CNT_W-1 and does not wrap.
- squash_count:
  - += popcount(flush & stage_valid) per cycle, using the pre-edge valid.
  - Saturates by clamping, with no wrap even on a multi-entry add.
- count_clr=1: both counters <=0 that edge. Clear wins over a simultaneous increment.
- in_valid while in_ready=0: input is ignored (not captured). The upstream source must hold its data.
- DEPTH=1: stage 0 is also the last stage, and rule 4 never applies.
- All outputs are registered except in_ready. No combinational path from in_data to any output.

Decomposition:
- Package pipe_ctl_pkg:
  - function sat_add(count, inc, CNT_W) for clamped addition.
  - function popcount over DEPTH bits.
- Sub-module pipe_stage_cell:
  - one stage's valid+data register implementing rules 1-5.
  - inputs: flush, hold, bubble_in, prev_valid, prev_data.
  - instantiated DEPTH times in a generate loop.
  - the top computes hold[] and the counters.

Test Plan:
1. Flow (DEPTH=4, BUBBLE=0x13):
   - Stimulus: drive 0xA0,0xA1,0xA2 valid on consecutive cycles.
   - Required: out_data=0xA0 with out_valid=1 at cycle 4, then 0xA1, then 0xA2. stall_count=0.
2. Stall bubble:
   - Stimulus: stall[1]=1 for 2 cycles with stages holding A3,A2,A1,A0.
   - Required: stages 0-1 frozen (A3,A2). Stage 2 receives BUBBLE/valid=0 each stall cycle. in_ready=0. stall_count=2.
3. Flush vs stall:
   - Stimulus: stall[2]=1 and flush[2]=1 in the same cycle, stage 2 valid.
   - Required: stage 2 -> valid=0, data=0x13. Stages 0-1 held. squash_count=1.
4. Multi-squash and saturation:
   - Stimulus: CNT_W=2, squash_count=2, flush=4'b0111 with all stages valid.
   - Required: squash_count=3 (clamped). A count_clr pulse on the next edge -> 0, even if the flush repeats.
5. Async reset mid-operation:
   - Stimulus: assert rst between clock edges while stall=1 and the pipe is full.
   - Required: immediately stage_valid=0, all data=BUBBLE, counters=0. After release with stall=0, in_ready=1.
6. Ignored input:
   - Stimulus: in_valid=1, in_data=0xBB while stall[3]=1.
   - Required: 0xBB is never seen in any stage. After the stall drops, the next valid input enters normally.
